// File: rtl/datamem_arbiter.sv
// Sequencer/arbiter sharing one single-port synchronous data RAM between the
// CPU MEM stage and one external requester, with bounded external starvation.
//
// Handshake semantics: a CPU access completes in the cycle where cpu_req_i=1
// and cpu_stall_o=0; an external request is accepted in the cycle where
// ext_valid_i=1 and ext_ready_o=1, and its read data is returned by a
// one-cycle ext_rvalid_o pulse. Requesters hold their fields until then.
module datamem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ext_valid_i,
  output logic              ext_ready_o,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              ext_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              dbg_state_o,
  output logic              dbg_owner_o,
  output logic [1:0]        dbg_wcnt_o,
  output logic [3:0]        dbg_streak_o
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_e;

  localparam logic       OWN_CPU    = 1'b0;
  localparam logic       OWN_EXT    = 1'b1;
  localparam logic [1:0] RD_LAT_C   = 2'(RD_LAT);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [3:0]        streak_q, streak_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              cpu_win, ext_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      wcnt_q      <= '0;
      streak_q    <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wcnt_q      <= wcnt_d;
      streak_q    <= streak_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wcnt_d       = wcnt_q;
    streak_d     = streak_q;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    cpu_win      = 1'b0;
    ext_win      = 1'b0;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    cpu_stall_o  = 1'b0;
    ext_ready_o  = 1'b0;
    ext_rvalid_o = 1'b0;
    cpu_rdata_o  = cpu_rdata_q;
    ext_rdata_o  = ext_rdata_q;

    if (rst_i) begin
      // Held registers still show their old value in the first reset cycle.
      cpu_rdata_o = '0;
      ext_rdata_o = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cpu_win = cpu_req_i && !(ext_valid_i && (streak_q == STREAK_MAX));
          ext_win = ext_valid_i && !cpu_win;
          if (cpu_win) begin
            mem_en_o    = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            cpu_stall_o = !cpu_we_i;
            if (!cpu_we_i) begin
              state_d = S_RD_WAIT;
              owner_d = OWN_CPU;
              wcnt_d  = RD_LAT_C;
            end
            if (ext_valid_i && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + 4'd1;
            end
          end else if (ext_win) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ext_we_i;
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
            ext_ready_o = 1'b1;
            cpu_stall_o = cpu_req_i;
            streak_d    = '0;
            if (!ext_we_i) begin
              state_d = S_RD_WAIT;
              owner_d = OWN_EXT;
              wcnt_d  = RD_LAT_C;
            end
          end
        end
        S_RD_WAIT: begin
          cpu_stall_o = cpu_req_i;
          if (wcnt_q == 2'd1) begin
            state_d = S_IDLE;
            wcnt_d  = '0;
            if (owner_q == OWN_CPU) begin
              cpu_rdata_o = mem_rdata_i;
              cpu_rdata_d = mem_rdata_i;
              cpu_stall_o = 1'b0;
            end else begin
              ext_rvalid_o = 1'b1;
              ext_rdata_o  = mem_rdata_i;
              ext_rdata_d  = mem_rdata_i;
            end
          end else begin
            wcnt_d = wcnt_q - 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (!ext_valid_i) begin
        streak_d = '0;
      end
    end
  end

  assign dbg_state_o  = state_q;
  assign dbg_owner_o  = owner_q;
  assign dbg_wcnt_o   = wcnt_q;
  assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: directed scenarios plus randomized concurrent CPU and
// external traffic, checked by a monitor against per-address reference contents.
module tb_datamem_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ext_valid, ext_ready, ext_we, ext_rvalid;
  logic [15:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        dbg_state, dbg_owner;
  logic [1:0]  dbg_wcnt;
  logic [3:0]  dbg_streak;

  datamem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .ext_valid_i(ext_valid), .ext_ready_o(ext_ready), .ext_we_i(ext_we),
    .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata), .ext_rdata_o(ext_rdata),
    .ext_rvalid_o(ext_rvalid),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .dbg_state_o(dbg_state), .dbg_owner_o(dbg_owner),
    .dbg_wcnt_o(dbg_wcnt), .dbg_streak_o(dbg_streak)
  );

  // ---------------- RAM environment ----------------
  function automatic logic [15:0] init_val(int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  logic [15:0] ram [0:255];
  logic [15:0] rd_pipe [0:RD_LAT-1];
  bit          ram_fill = 1'b1;

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_fill <= 1'b0;
    end else if (mem_en && mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr[7:0]] : 16'hDEAD;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] ref_mem [0:255];
  logic [15:0] cpu_exp_q[$];
  logic [15:0] ext_exp_q[$];
  logic [15:0] last_cpu_rd, last_ext_rd;
  int          checks = 0;
  int          errors = 0;
  int          starve_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!mem_en) chk("idle_mem_fields", {13'd0, mem_we, |mem_addr, |mem_wdata}, 32'd0);
    if (rst) begin
      chk("rst_outputs", {mem_en, ext_ready, ext_rvalid, cpu_stall}, 32'd0);
      chk("rst_rdata", {cpu_rdata, ext_rdata}, 32'd0);
      last_cpu_rd = '0;
      last_ext_rd = '0;
      starve_cnt  = 0;
    end else begin
      if (ext_ready) begin
        chk("ext_issue_fields", {mem_en, mem_we, mem_addr}, {1'b1, ext_we, ext_addr});
        if (ext_we) chk("ext_issue_wdata", mem_wdata, ext_wdata);
      end else if (mem_en) begin
        chk("cpu_issue_fields", {cpu_req, mem_we, mem_addr}, {1'b1, cpu_we, cpu_addr});
        if (cpu_we) chk("cpu_issue_wdata", mem_wdata, cpu_wdata);
      end
      if (cpu_req && !cpu_stall && !cpu_we) begin
        if (cpu_exp_q.size() == 0) chk("cpu_load_unexpected", 1, 0);
        else begin
          last_cpu_rd = cpu_exp_q.pop_front();
          chk("cpu_rdata", cpu_rdata, last_cpu_rd);
        end
      end else begin
        chk("cpu_rdata_hold", cpu_rdata, last_cpu_rd);
      end
      if (ext_rvalid) begin
        if (ext_exp_q.size() == 0) chk("ext_rvalid_unexpected", 1, 0);
        else begin
          last_ext_rd = ext_exp_q.pop_front();
          chk("ext_rdata", ext_rdata, last_ext_rd);
        end
      end else begin
        chk("ext_rdata_hold", ext_rdata, last_ext_rd);
      end
      if (ext_ready || !ext_valid) starve_cnt = 0;
      else if (mem_en) begin
        starve_cnt++;
        chk("ext_starvation", (starve_cnt > STARVE_MAX) ? 1 : 0, 0);
      end
    end
  end

  // ---------------- drivers (entered and left just after a rising edge) ----------------
  task automatic cpu_op(input bit we, input logic [15:0] a, input logic [15:0] d,
                        output int stalls);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) ref_mem[a[7:0]] = d;
    else    cpu_exp_q.push_back(ref_mem[a[7:0]]);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 100) begin chk("cpu_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ext_op(input bit we, input logic [15:0] a, input logic [15:0] d,
                        input bit wait_rv, output int lat);
    int n = 0;
    ext_valid = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    if (we) ref_mem[a[7:0]] = d;
    else    ext_exp_q.push_back(ref_mem[a[7:0]]);
    forever begin
      @(negedge clk);
      if (ext_ready) break;
      n++;
      if (n > 100) begin chk("ext_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    ext_valid = 1'b0;
    lat = 0;
    if (wait_rv) begin
      do begin
        if (lat > 0) begin @(posedge clk); #1; end
        @(negedge clk);
        lat++;
      end while (!ext_rvalid && lat < 100);
      @(posedge clk); #1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int st, lat, n;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hAAAA;
    ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 16'h0060; ext_wdata = 16'h6666;

    // Reset held with both requesters active.
    repeat (3) begin
      @(negedge clk);
      chk("rst_state", {dbg_state, dbg_wcnt, dbg_streak}, 32'd0);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cpu_issue", {mem_en, mem_we, ext_ready, cpu_stall}, 32'b1100);
    ref_mem[8'h50] = 16'hAAAA;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("post_rst_ext_issue", ext_ready, 1);
    ref_mem[8'h60] = 16'h6666;
    step();
    ext_valid = 1'b0;

    // CPU store then load.
    cpu_op(1'b1, 16'h0010, 16'hBEEF, st);
    chk("store_stalls", st, 0);
    cpu_op(1'b0, 16'h0010, 16'h0000, st);
    chk("load_stalls", st, RD_LAT);

    // External write then read with the CPU idle.
    ext_op(1'b1, 16'h0020, 16'h1234, 1'b0, lat);
    ext_op(1'b0, 16'h0020, 16'h0000, 1'b1, lat);
    chk("ext_read_latency", lat, RD_LAT);

    // Continuous CPU stores against a continuously pending external write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'hC0DE;
    ext_valid = 1'b1; ext_we = 1'b1; ext_addr = 16'h0040; ext_wdata = 16'h4444;
    ref_mem[8'h30] = 16'hC0DE;
    ref_mem[8'h40] = 16'h4444;
    for (int k = 1; k <= 2 * (STARVE_MAX + 1); k++) begin
      @(negedge clk);
      chk("starve_ext_ready", ext_ready, (k % (STARVE_MAX + 1) == 0) ? 1 : 0);
      chk("starve_cpu_stall", cpu_stall, (k % (STARVE_MAX + 1) == 0) ? 1 : 0);
      step();
    end
    cpu_req = 1'b0;
    ext_valid = 1'b0;

    // CPU load arrives while an external read is in flight.
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
    ext_exp_q.push_back(ref_mem[8'h20]);
    @(negedge clk);
    chk("inflight_ext_issue", ext_ready, 1);
    step();
    ext_valid = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    cpu_exp_q.push_back(ref_mem[8'h30]);
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      chk("inflight_wait", {cpu_stall, mem_en, ext_rvalid}, {1'b1, 1'b0, (k == RD_LAT)});
      step();
    end
    @(negedge clk);
    chk("inflight_cpu_issue", {mem_en, ext_ready, cpu_stall, mem_addr}, {3'b101, 16'h0030});
    n = 0;
    while (cpu_stall && n < 100) begin step(); @(negedge clk); n++; end
    chk("inflight_cpu_done", cpu_stall, 0);
    step();
    cpu_req = 1'b0;

    // Reset one cycle after an external read issue abandons it.
    ext_valid = 1'b1; ext_we = 1'b0; ext_addr = 16'h0020;
    @(negedge clk);
    chk("abandon_ext_issue", ext_ready, 1);
    step();
    rst = 1'b1;
    ext_valid = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    for (int k = 0; k < 2 * RD_LAT + 2; k++) begin
      @(negedge clk);
      chk("abandon_no_rvalid", {dbg_state, ext_rvalid}, 32'd0);
      step();
    end
    ext_op(1'b0, 16'h0020, 16'h0000, 1'b1, lat);
    chk("abandon_next_latency", lat, RD_LAT);

    // Randomized concurrent traffic; CPU and external use disjoint address halves.
    fork
      begin
        int s;
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 3)) step();
          cpu_op(1'($urandom_range(0, 1)), 16'($urandom_range(0, 127)), 16'($urandom), s);
        end
      end
      begin
        int l;
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 3)) step();
          ext_op(1'($urandom_range(0, 1)), 16'($urandom_range(128, 255)), 16'($urandom),
                 1'b0, l);
        end
      end
    join

    repeat (RD_LAT + 3) @(negedge clk);
    chk("cpu_queue_drained", cpu_exp_q.size(), 0);
    chk("ext_queue_drained", ext_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Sequencer and arbiter for the single-port synchronous data RAM behind the MEM stage. It shares the RAM between the CPU's MEM stage and one external requester, such as the image loader or display reader. Requests from the CPU come from the EX/MEM pipeline register's memory-access flags. The block owns the RAM control pins, freezes the pipeline with `cpu_stall` while a CPU load is in flight, and bounds external-port starvation with a grant-streak counter.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `RD_LAT`, 1, RAM read latency in cycles (legal 1..3)
- `STARVE_MAX`, 4, max consecutive CPU grants while external is pending (legal 1..15)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cpu_req`  in  1  MEM stage holds a load/store (held stable while `cpu_stall`=1)
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_rdata`  out  DATA_W  CPU load data
- `cpu_stall`  out  1  freeze IF/ID/EX/MEM pipeline registers
- `ext_valid`  in  1  external request valid
- `ext_ready`  out  1  external request accepted this cycle
- `ext_we`, `ext_addr`, `ext_wdata`  in  1/ADDR_W/DATA_W  external request fields
- `ext_rdata`  out  DATA_W  external read data
- `ext_rvalid`  out  1  one-cycle pulse, `ext_rdata` valid
- `mem_en`, `mem_we`  out  1/1  RAM enable / write enable
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  RAM address / write data
- `mem_rdata`  in  DATA_W  RAM read data, valid `RD_LAT` cycles after the issue cycle

## Operation
- States: `IDLE` and `RD_WAIT`. `RD_WAIT` carries an owner bit (CPU/EXT) and a wait counter `wcnt`.
- Only one access is outstanding at a time. The issue decision in `IDLE` is combinational from inputs.
- Arbitration in `IDLE`:
  - CPU only → CPU granted.
  - EXT only → EXT granted.
  - Both → CPU granted unless `streak`==`STARVE_MAX`, in which case EXT is granted.
- Issue cycle: `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` come from the winner. When `mem_en`=0, `mem_we`=0 and `mem_addr`/`mem_wdata`=0.
- Write grant: completes in the issue cycle and the state stays `IDLE`.
  - CPU store: `cpu_stall`=0, so zero stall cycles.
  - EXT write: `ext_ready`=1; no rvalid follows.
- Read grant: next state is `RD_WAIT` with `wcnt`=`RD_LAT`, decrementing each cycle. At `wcnt`==1 (final cycle) the data is returned and the next state is `IDLE`. No new issue happens in the final cycle.
- CPU data return: in the final cycle `cpu_rdata`=`mem_rdata` and `cpu_stall`=0. Otherwise `cpu_rdata` holds the last captured value.
- EXT data return: `ext_ready`=1 in the issue cycle. In the final cycle `ext_rvalid`=1 and `ext_rdata`=`mem_rdata`. Otherwise `ext_rdata` holds the last value.
- `cpu_stall`=1 when `cpu_req`=1 and the CPU's access does not complete this cycle. That covers a losing arbitration, a CPU load issue cycle, non-final CPU wait cycles, and any `RD_WAIT` owned by EXT.
- `ext_ready`=0 whenever the state is not `IDLE` or the CPU wins.
- Streak counter (`streak`, saturating at `STARVE_MAX`):
  - +1 on each CPU grant with `ext_valid`=1.
  - Clears on an EXT grant.
  - Clears on any cycle with `ext_valid`=0.
- Protocol: the EXT fields must stay stable while `ext_valid`=1 and `ext_ready`=0. Dropping valid early is illegal and the behaviour is undefined.

## Timing
- Reset values (while `rst`=1 and after it): state `IDLE`, `streak`=0, `wcnt`=0, held rdata registers 0.
- Outputs while `rst`=1: `mem_en`=0, `mem_we`=0, `ext_ready`=0, `ext_rvalid`=0, `cpu_stall`=0, `cpu_rdata`=0, `ext_rdata`=0.
- Reset mid-read: the access is abandoned with no `ext_rvalid` and no CPU data. The first issue is possible in the first cycle with `rst`=0.
- Latency:
  - Store: 0 stall cycles.
  - CPU load: `RD_LAT` stall cycles, with data in cycle issue+`RD_LAT`.
  - EXT read: `ext_rvalid` at issue+`RD_LAT`.
- Back-to-back reads from one requester issue every `RD_LAT`+1 cycles. Writes can issue every cycle.
- The worst-case EXT wait with continuous CPU traffic is `STARVE_MAX` CPU grants. The EXT grant then occurs in the next `IDLE` cycle.

## Test plan
- `rst` held 3 cycles with `cpu_req`=1 and `ext_valid`=1 → `mem_en`=0, `cpu_stall`=0, `ext_ready`=0 throughout; first cycle after → CPU issues.
- CPU store addr 0x0010 data 0xBEEF, then load 0x0010 (`RD_LAT`=1) → store cycle `cpu_stall`=0 with `mem_we`=1; load issue cycle `cpu_stall`=1, next cycle `cpu_stall`=0 and `cpu_rdata`=0xBEEF.
- EXT read 0x0020 (RAM holds 0x1234) with CPU idle → `ext_ready`=1 at issue, `ext_rvalid`=1 exactly 1 cycle later with `ext_rdata`=0x1234; with `RD_LAT`=3 → rvalid 3 cycles later.
- Continuous CPU stores plus `ext_valid`=1 (`STARVE_MAX`=4) → 4 CPU grants, then EXT granted on the 5th `IDLE` cycle with `cpu_stall`=1 in that cycle; `streak` restarts at 0.
- EXT read in flight (`RD_LAT`=2) when `cpu_req` rises → `cpu_stall`=1 until the state returns to `IDLE`, then the CPU issues.
- `rst` asserted in the cycle after an EXT read issue → no `ext_rvalid` ever, state `IDLE`, next request issues normally.
